// File: rtl/apple2_fdd_pkg.sv
// Shared types and constants for the Disk II track loader.
// The optional write-back path is compiled in with FDD_WRITEBACK_EN.
package apple2_fdd_pkg;

  localparam int SECTORS_PER_TRACK = 13;
  localparam int SD_SECTOR_BYTES   = 512;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_XFER,
    RD_REQ,
    RD_XFER
  } fdd_state_t;

  // Internal loader state exposed so checkers can observe it directly.
  typedef struct packed {
    fdd_state_t state;
    logic       valid;
    logic       dirty;
    logic       remount_pend;
  } fdd_dbg_t;

endpackage

// File: rtl/fdd_lba_calc.sv
// Converts a track number to its first SD sector: track * 13 as a shift-add.
module fdd_lba_calc
  import apple2_fdd_pkg::*;
#(
  parameter int TRACK_W = 6
) (
  input  logic [TRACK_W-1:0] track,
  output logic [31:0]        lba
);

  logic [TRACK_W+3:0] t_ext;
  logic [TRACK_W+3:0] prod;

  // 13t = 8t + 4t + t, zero-extended to the 32-bit LBA.
  always_comb begin
    t_ext = {4'b0000, track};
    prod  = (t_ext << 3) + (t_ext << 2) + t_ext;
    lba   = {{(28-TRACK_W){1'b0}}, prod};
  end

endmodule

// File: rtl/fdd_track_loader.sv
// Disk II track cache loader: fetches the sectors of the head's current
// track from SD image 0 into track RAM and stalls the CPU meanwhile.
// Define FDD_WRITEBACK_EN to flush a dirty track before loading the next.
//
// SD handshake: sd_rd / sd_wr is a request held high until the rising edge
// of sd_ack is sampled, then dropped on the following cycle. sd_ack stays
// high for the whole 512-byte transfer; its falling edge marks the sector
// complete. Edges are found against a one-cycle delayed copy of sd_ack.
module fdd_track_loader
  import apple2_fdd_pkg::*;
#(
  parameter int SECTORS_PER_TRACK = 13,
  parameter int TRACK_W           = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               disk_we,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic               busy,
  output fdd_dbg_t           dbg
);

  fdd_state_t         state;
  logic [TRACK_W-1:0] cur_track;
  logic [TRACK_W-1:0] new_track;
  logic               valid;
  logic               dirty;
  logic               remount_pend;
  logic               ack_d;
  logic               ack_rise;
  logic               ack_fall;
  logic               load_need;
  logic               last_sec;
  logic               abort;
  logic [31:0]        lba_trk;
  logic [31:0]        lba_cur;

  fdd_lba_calc #(.TRACK_W(TRACK_W)) u_lba_trk (.track(track),     .lba(lba_trk));
  fdd_lba_calc #(.TRACK_W(TRACK_W)) u_lba_cur (.track(cur_track), .lba(lba_cur));

`ifdef FDD_WRITEBACK_EN
  logic [31:0] lba_new;
  logic        dirty_now;
  fdd_lba_calc #(.TRACK_W(TRACK_W)) u_lba_new (.track(new_track), .lba(lba_new));
  // A core write on the trigger cycle still counts toward the flush decision.
  assign dirty_now = dirty | (disk_we & valid);
`else
  logic unused_disk_we;
  assign unused_disk_we = disk_we;
`endif

  assign ack_rise  = sd_ack & ~ack_d;
  assign ack_fall  = ~sd_ack & ack_d;
  assign load_need = ~valid | (track != cur_track) | remount_pend;
  assign last_sec  = (track_sec == 4'(SECTORS_PER_TRACK - 1));
  assign abort     = remount_pend | img_mounted;

  // Debug view of the loader state.
  always_comb begin
    dbg.state        = state;
    dbg.valid        = valid;
    dbg.dirty        = dirty;
    dbg.remount_pend = remount_pend;
  end

  // Loader FSM with registered request, stall and sector outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      sd_lba       <= 32'd0;
      track_sec    <= 4'd0;
      cpu_wait     <= 1'b0;
      busy         <= 1'b0;
      cur_track    <= '0;
      new_track    <= '0;
      valid        <= 1'b0;
      dirty        <= 1'b0;
      remount_pend <= 1'b0;
      // Starting "high" hides an ack still in flight across reset until it
      // has been seen low.
      ack_d        <= 1'b1;
    end else begin
      ack_d <= sd_ack;
      if (img_mounted && state != IDLE) remount_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (img_mounted) begin
            valid <= 1'b0;
            dirty <= 1'b0;
          end else begin
`ifdef FDD_WRITEBACK_EN
            if (disk_we && valid) dirty <= 1'b1;
`endif
            if (load_need) begin
              remount_pend <= 1'b0;
              new_track    <= track;
              if (!img_present) begin
                cur_track <= track;
                valid     <= 1'b0;
              end else begin
                busy      <= 1'b1;
                cpu_wait  <= 1'b1;
                track_sec <= 4'd0;
`ifdef FDD_WRITEBACK_EN
                if (dirty_now && valid && !remount_pend) begin
                  state  <= WB_REQ;
                  sd_wr  <= 1'b1;
                  sd_lba <= lba_cur;
                end else
`endif
                begin
                  state  <= RD_REQ;
                  sd_rd  <= 1'b1;
                  sd_lba <= lba_trk;
                end
              end
            end
          end
        end
`ifdef FDD_WRITEBACK_EN
        WB_REQ: begin
          if (ack_rise) begin
            sd_wr <= 1'b0;
            state <= WB_XFER;
          end
        end
        WB_XFER: begin
          if (ack_fall) begin
            if (abort) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cpu_wait  <= 1'b0;
              track_sec <= 4'd0;
              valid     <= 1'b0;
              dirty     <= 1'b0;
            end else if (last_sec) begin
              dirty     <= 1'b0;
              track_sec <= 4'd0;
              sd_lba    <= lba_new;
              sd_rd     <= 1'b1;
              state     <= RD_REQ;
            end else begin
              track_sec <= track_sec + 4'd1;
              sd_lba    <= sd_lba + 32'd1;
              sd_wr     <= 1'b1;
              state     <= WB_REQ;
            end
          end
        end
`endif
        RD_REQ: begin
          if (ack_rise) begin
            sd_rd <= 1'b0;
            state <= RD_XFER;
          end
        end
        RD_XFER: begin
          if (ack_fall) begin
            if (abort) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cpu_wait  <= 1'b0;
              track_sec <= 4'd0;
              valid     <= 1'b0;
              dirty     <= 1'b0;
            end else if (last_sec) begin
              track_sec <= 4'd0;
              cur_track <= new_track;
              valid     <= 1'b1;
              busy      <= 1'b0;
              cpu_wait  <= 1'b0;
              state     <= IDLE;
            end else begin
              track_sec <= track_sec + 4'd1;
              sd_lba    <= sd_lba + 32'd1;
              sd_rd     <= 1'b1;
              state     <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fdd_track_loader.md
# fdd_track_loader

Floppy track cache controller between the HPS SD-block interface (virtual disk 0) and the Apple II core's Disk II track RAM. It watches the head track number from the core, fetches the 13 × 512-byte sectors of that track from the mounted image into track RAM, and stalls the CPU while doing so. Optionally, it writes a modified track back to the image before loading the next one.

## Interface
Parameters:
- SECTORS_PER_TRACK, 13, 512-byte SD sectors per Disk II track (6656 B nibble track)
- TRACK_W, 6, width of track number

Ports:
- clk_sys  in  1  system clock (14 MHz core clock)
- reset_n  in  1  asynchronous, active-low reset
- track  in  TRACK_W  current head track from core
- img_mounted  in  1  one-cycle pulse: new image mounted on disk 0
- img_present  in  1  level: mounted image size ≠ 0
- disk_we  in  1  core wrote a byte into track RAM (dirty marker)
- sd_lba  out  32  sector address to HPS
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  HPS transfer in progress (high for the whole 512-byte transfer)
- track_sec  out  4  sector index within track; upper bits of track RAM address
- cpu_wait  out  1  stall CPU
- busy  out  1  state ≠ IDLE

## Operation
- State machine states:
  - IDLE
  - WB_REQ / WB_XFER: write-back
  - RD_REQ / RD_XFER: read
- Internal registers:
  - cur_track
  - valid: cur_track contents are in RAM
  - dirty
  - remount_pend
- Load trigger in IDLE: img_present and (¬valid, or track ≠ cur_track, or remount_pend).
  - On trigger, capture new_track ← track and clear remount_pend.
  - If dirty, valid, and no remount: go to WB_REQ at LBA = 13·cur_track. Otherwise go to RD_REQ at LBA = 13·new_track.
- Trigger with img_present = 0: cur_track ← track, valid ← 0, no transfer.
- REQ state:
  - Drive sd_rd (or sd_wr) high.
  - On the sd_ack rising edge, drop the request and enter XFER.
- XFER state, on the sd_ack falling edge:
  - If track_sec = SECTORS_PER_TRACK−1: track_sec ← 0.
    - After write-back: dirty ← 0, then go to RD_REQ at 13·new_track.
    - After read: cur_track ← new_track, valid ← 1, go to IDLE.
  - Otherwise: track_sec +1, sd_lba +1, back to REQ.
- disk_we sets dirty only in IDLE with valid = 1. It is ignored while busy.
- img_mounted pulse:
  - In IDLE: valid ← 0, dirty ← 0.
  - While busy: latch remount_pend. The current sector completes, the rest of the sequence is abandoned, and the FSM returns to IDLE with valid ← 0 and dirty ← 0.
- Track change while busy: not sampled; it is re-compared on return to IDLE.
- LBA arithmetic: 13·t = (t<<3)+(t<<2)+t, zero-extended to 32 bits. Increment is 32-bit with no wrap handling (max track 63 → LBA < 832).
- cpu_wait is high from trigger until the final read sector's ack falls, continuously across all sectors and the write-back.

## Timing
- Reset values: sd_rd = sd_wr = cpu_wait = busy = 0; sd_lba = 0; track_sec = 0; valid = dirty = remount_pend = 0.
- Trigger is registered. cpu_wait, busy, and the request go high 1 cycle after the triggering condition.
- Request deasserts on the cycle after the sd_ack rise is sampled. sd_ack is already synchronous to clk_sys; edge detection uses a 1-cycle delayed copy.
- Next sector request is issued 1 cycle after the sd_ack fall.
- cpu_wait and busy drop 1 cycle after the last sd_ack fall.
- sd_lba and track_sec are stable from request assertion until the sd_ack fall. track_sec must not change while sd_ack = 1.
- Reset during a transfer aborts immediately. sd_ack may still be high, and it is ignored until it is low for one cycle.

## Configuration
- FDD_WRITEBACK_EN defined: dirty tracking and the WB states are present; sd_wr is functional.
- FDD_WRITEBACK_EN undefined: sd_wr is tied 0, disk_we is unused, the WB states are removed, and the disk is read-only (core writes are lost on track change).

## Structure
- Package apple2_fdd_pkg holds:
  - state enum fdd_state_t (IDLE, WB_REQ, WB_XFER, RD_REQ, RD_XFER)
  - constant SECTORS_PER_TRACK = 13
  - constant SD_SECTOR_BYTES = 512
- One sub-module, fdd_lba_calc: combinational track·13 via shift-add, parameterised by TRACK_W.

## Test plan
- Reset, img_present = 1, track = 0 → 13 reads with LBA 0..12; cpu_wait high throughout; then valid = 1 and busy = 0.
- Track 0 → 17 with the model acking each request after 5 cycles → reads of LBA 221..233; track_sec steps 0..12; cpu_wait drops 1 cycle after the 13th ack fall.
- With FDD_WRITEBACK_EN: disk_we in IDLE on track 3, then track → 4 → writes to LBA 39..51, then reads of LBA 52..64; dirty = 0 afterwards.
- img_mounted during the 5th sector of a read → that sector finishes, no further requests, busy drops, then a full reload of the current track with no write-back.
- img_present = 0 and track changes → no sd_rd, and cpu_wait stays 0.
- reset_n asserted while sd_ack = 1 → all outputs 0 immediately; after release, a fresh load starts at sector 0.
